saber_acc_unloader: RTL

Output side of the Saber parallel MAC array. Once a polynomial product is complete, the block captures the 256-coefficient, 3328-bit accumulator in one cycle and streams it to the 64-bit data memory as consecutive words, using a valid/ready handshake. It is the reader for the MAC array's accumulator output and lets the array start the next product as soon as capture completes.

---
 rtl/saber_acc_unloader_if.sv | 27 ++
 rtl/saber_acc_unloader.sv | 93 +++++++++
 2 files changed

// File: rtl/saber_acc_unloader_if.sv
// rtl/saber_acc_unloader_if.sv - capture request and output word stream bundle of the accumulator unloader
interface saber_acc_unloader_if #(
  parameter int N_COEF = 256,
  parameter int Q_W    = 13,
  parameter int BUS_W  = 64
);
  logic                    load;
  logic [N_COEF*Q_W-1:0]   acc_in;
  logic                    load_ready;
  logic [BUS_W-1:0]        dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    dout_last;
  logic                    done;

  // master: the unloader itself (produces the word stream)
  modport master (
    input  load, acc_in, dout_ready,
    output load_ready, dout, dout_valid, dout_last, done
  );

  // slave: the MAC array / data memory side
  modport slave (
    output load, acc_in, dout_ready,
    input  load_ready, dout, dout_valid, dout_last, done
  );
endinterface

// File: rtl/saber_acc_unloader.sv
// rtl/saber_acc_unloader.sv - captures the MAC accumulator and streams it as words; SABER_UNLOAD_ROUND_EN enables q->p rounding
module saber_acc_unloader #(
  parameter int N_COEF = 256,
  parameter int Q_W    = 13,
  parameter int BUS_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  saber_acc_unloader_if.master  bus
);

`ifdef SABER_UNLOAD_ROUND_EN
  localparam int C_W = Q_W - 3;
`else
  localparam int C_W = Q_W;
`endif
  localparam int PW  = N_COEF * C_W;
  localparam int NW  = PW / BUS_W;
  localparam int WCW = $clog2(NW + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t           state;
  logic [PW-1:0]    sr;
  logic [PW-1:0]    img;
  logic [WCW-1:0]   wcnt;
  logic             dout_valid_q;
  logic             dout_last_q;
  logic             done_q;

`ifdef SABER_UNLOAD_ROUND_EN
  // Round each coefficient q->p: add half an LSB of p, wrap mod 2^Q_W, drop 3 bits
  for (genvar i = 0; i < N_COEF; i++) begin : g_round
    logic [Q_W-1:0] c_sum;
    assign c_sum = bus.acc_in[i*Q_W +: Q_W] + Q_W'(4);
    assign img[i*C_W +: C_W] = c_sum[Q_W-1:3];
  end
`else
  // Raw build: the accumulator is already wrapped, so capture is a plain copy
  assign img = bus.acc_in;
`endif

  // Capture on load, then shift out one word per accepted beat; done pulses after the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      wcnt         <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr           <= img;
            wcnt         <= '0;
            dout_valid_q <= 1'b1;
            dout_last_q  <= (NW == 1);
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (bus.dout_ready) begin
            sr   <= {{BUS_W{1'b0}}, sr[PW-1:BUS_W]};
            wcnt <= wcnt + WCW'(1);
            if (dout_last_q) begin
              state        <= IDLE;
              wcnt         <= '0;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              dout_last_q <= ((wcnt + WCW'(1)) == WCW'(NW - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.dout       = sr[BUS_W-1:0];
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.done       = done_q;

endmodule
